// File: rtl/m_dm_lat.sv
// Multi-cycle MEM-stage data memory with byte/half/word access and a busy/rdValid handshake.
// Malformed requests are rejected with a single-cycle addrErr pulse and have no side effects.
module m_dm_lat #(
  parameter int          DEPTH_WORDS = 4096,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [31:0] memDst,
  input  logic [31:0] memWd,
  input  logic [3:0]  memOp,
  output logic [31:0] rd,
  output logic        busy,
  output logic        rdValid,
  output logic        addrErr
);

  localparam int          IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int          CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  localparam logic [3:0] OP_W  = 4'd0;
  localparam logic [3:0] OP_HU = 4'd1;
  localparam logic [3:0] OP_H  = 4'd2;
  localparam logic [3:0] OP_BU = 4'd3;
  localparam logic [3:0] OP_B  = 4'd4;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [IDX_W-1:0]   r_idx;
  logic [1:0]         r_lane;
  logic [31:0]        r_wd;
  logic [3:0]         r_op;
  logic               r_write;
  logic [31:0]        r_rd;
  logic               r_busy, r_rd_valid, r_addr_err;
  logic [31:0]        r_mem [DEPTH_WORDS];

  logic [31:0] w_offset;
  logic        w_req, w_reject, w_accept, w_err, w_commit;
  logic [31:0] w_word, w_wr_word, w_ld_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    w_offset = memDst - BASE_ADDR;
    w_req    = memRead | memWrite;
    w_reject = (memRead & memWrite)
             | (memOp > OP_B)
             | ((memOp == OP_W) && (memDst[1:0] != 2'b00))
             | (((memOp == OP_HU) || (memOp == OP_H)) && memDst[0])
             | (memDst < BASE_ADDR)
             | ({1'b0, w_offset} >= SPAN);
    w_accept = (r_state == S_IDLE) && w_req && !w_reject;
    w_err    = (r_state == S_IDLE) && w_req && w_reject;
    w_commit = (r_state == S_BUSY) && (r_cnt == '0);

    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_BUSY;
      S_BUSY: if (w_commit) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Little-endian lane extraction and merge on the latched request word.
  always_comb begin
    w_word    = r_mem[r_idx];
    w_byte    = w_word[{r_lane, 3'b000} +: 8];
    w_half    = w_word[{r_lane[1], 4'b0000} +: 16];
    w_wr_word = w_word;
    w_ld_word = w_word;
    case (r_op)
      OP_HU:   w_ld_word = {16'h0000, w_half};
      OP_H:    w_ld_word = {{16{w_half[15]}}, w_half};
      OP_BU:   w_ld_word = {24'h000000, w_byte};
      OP_B:    w_ld_word = {{24{w_byte[7]}}, w_byte};
      default: w_ld_word = w_word;
    endcase
    case (r_op)
      OP_W:        w_wr_word = r_wd;
      OP_HU, OP_H: w_wr_word[{r_lane[1], 4'b0000} +: 16] = r_wd[15:0];
      OP_BU, OP_B: w_wr_word[{r_lane, 3'b000} +: 8] = r_wd[7:0];
      default:     w_wr_word = w_word;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_lane     <= 2'b00;
      r_wd       <= 32'h0;
      r_op       <= OP_W;
      r_write    <= 1'b0;
      r_rd       <= 32'h0;
      r_busy     <= 1'b0;
      r_rd_valid <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy     <= (w_state_nxt == S_BUSY);
      r_rd_valid <= w_commit;
      r_addr_err <= w_err;
      if (w_accept) begin
        r_cnt   <= CNT_W'(LATENCY - 1);
        r_idx   <= w_offset[IDX_W+1:2];
        r_lane  <= memDst[1:0];
        r_wd    <= memWd;
        r_op    <= memOp;
        r_write <= memWrite;
      end else if ((r_state == S_BUSY) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_commit && !r_write) r_rd <= w_ld_word;
    end
  end

  // NOTE: the array is architecturally cleared by reset, so it lives in flops, not a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'h0;
    end else if (w_commit && r_write) begin
      r_mem[r_idx] <= w_wr_word;
    end
  end

  assign rd      = r_rd;
  assign busy    = r_busy;
  assign rdValid = r_rd_valid;
  assign addrErr = r_addr_err;

endmodule

// File: tb/tb_m_dm_lat.sv
// Directed bench for m_dm_lat (LATENCY=2, BASE_ADDR=0, DEPTH_WORDS=4096):
// handshake timing, lane extraction/merge, rejections, reset abort and held requests.
module tb_m_dm_lat;

  logic        clk = 1'b0;
  logic        reset;
  logic        memRead, memWrite;
  logic [31:0] memDst, memWd;
  logic [3:0]  memOp;
  logic [31:0] rd;
  logic        busy, rdValid, addrErr;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_rd   = 32'h0;

  always #5 clk = ~clk;

  m_dm_lat #(
    .DEPTH_WORDS(4096),
    .BASE_ADDR  (32'h0000_0000),
    .LATENCY    (2)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .memRead (memRead),
    .memWrite(memWrite),
    .memDst  (memDst),
    .memWd   (memWd),
    .memOp   (memOp),
    .rd      (rd),
    .busy    (busy),
    .rdValid (rdValid),
    .addrErr (addrErr)
  );

  task automatic drive_idle();
    memRead  = 1'b0;
    memWrite = 1'b0;
    memDst   = 32'h0;
    memWd    = 32'h0;
    memOp    = 4'd0;
  endtask

  // Presents a request for one cycle; returns at the falling edge after the accept edge.
  task automatic issue(input logic r, input logic w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] op);
    @(negedge clk);
    memRead = r; memWrite = w; memDst = a; memWd = d; memOp = op;
    @(negedge clk);
    drive_idle();
  endtask

  // Issues a request and waits (bounded) for its rdValid pulse.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] op,
                        output logic [31:0] data, output bit got);
    issue(r, w, a, d, op);
    got  = 1'b0;
    data = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rdValid === 1'b1) begin
        got  = 1'b1;
        data = rd;
        break;
      end
    end
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, rdValid, addrErr, rd} !== 35'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: got busy=%b rdValid=%b addrErr=%b rd=%h, want all zero",
               busy, rdValid, addrErr, rd);
    end
    reset = 1'b0;
  endtask

  task automatic test_first_load();
    issue(1'b1, 1'b0, 32'h0, 32'h0, 4'd0);
    n_checks++;
    if (busy !== 1'b1 || rdValid !== 1'b0) begin
      n_errors++;
      $display("FAIL lw0_busy_c1: got busy=%b rdValid=%b, want 1 0", busy, rdValid);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || rdValid !== 1'b0) begin
      n_errors++;
      $display("FAIL lw0_busy_c2: got busy=%b rdValid=%b, want 1 0", busy, rdValid);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rdValid !== 1'b1 || rd !== 32'h0) begin
      n_errors++;
      $display("FAIL lw0_done: got busy=%b rdValid=%b rd=%h, want 0 1 00000000", busy, rdValid, rd);
    end
    @(negedge clk);
    n_checks++;
    if (rdValid !== 1'b0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL lw0_pulse: got rdValid=%b busy=%b, want 0 0", rdValid, busy);
    end
    exp_rd = 32'h0;
  endtask

  task automatic test_word_store_lanes();
    logic [31:0] addrs [4] = '{32'h11, 32'h13, 32'h12, 32'h10};
    logic [3:0]  ops   [4] = '{4'd3, 4'd4, 4'd1, 4'd0};
    logic [31:0] exps  [4] = '{32'h0000_0056, 32'h0000_0012, 32'h0000_1234, 32'h1234_5678};
    logic [31:0] data;
    bit          got;
    access(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'd0, data, got);
    n_checks++;
    if (!got || rd !== exp_rd) begin
      n_errors++;
      $display("FAIL sw_0x10: got rdValid_seen=%0d rd=%h, want 1 rd=%h (store keeps rd)", got, rd, exp_rd);
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, addrs[i], 32'h0, ops[i], data, got);
      n_checks++;
      if (!got || data !== exps[i]) begin
        n_errors++;
        $display("FAIL load_lane_%0d: addr=%h op=%0d got valid=%0d rd=%h, want %h",
                 i, addrs[i], ops[i], got, data, exps[i]);
      end
    end
    exp_rd = 32'h1234_5678;
  endtask

  task automatic test_byte_half();
    logic [31:0] data;
    bit          got;
    access(1'b0, 1'b1, 32'h20, 32'h1234_5680, 4'd3, data, got);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'd4, data, got);
    n_checks++;
    if (!got || data !== 32'hFFFF_FF80) begin
      n_errors++;
      $display("FAIL lb_0x20: got valid=%0d rd=%h, want ffffff80", got, data);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'd3, data, got);
    n_checks++;
    if (!got || data !== 32'h0000_0080) begin
      n_errors++;
      $display("FAIL lbu_0x20: got valid=%0d rd=%h, want 00000080", got, data);
    end
    access(1'b0, 1'b1, 32'h22, 32'h5555_BEEF, 4'd2, data, got);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'd0, data, got);
    n_checks++;
    if (!got || data !== 32'hBEEF_0080) begin
      n_errors++;
      $display("FAIL lw_0x20_merge: got valid=%0d rd=%h, want beef0080", got, data);
    end
    exp_rd = 32'hBEEF_0080;
  endtask

  task automatic test_reject();
    logic        rs   [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    logic        ws   [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [31:0] as   [5] = '{32'h6, 32'h5, 32'h4000, 32'h10, 32'h20};
    logic [31:0] ds   [5] = '{32'h0, 32'h0, 32'h0, 32'hDEAD_BEEF, 32'h1111_1111};
    logic [3:0]  ops  [5] = '{4'd0, 4'd2, 4'd0, 4'd7, 4'd0};
    logic [31:0] la   [4] = '{32'h4, 32'h10, 32'h20, 32'h3FFC};
    logic [31:0] le   [4] = '{32'h0, 32'h1234_5678, 32'hBEEF_0080, 32'h0};
    logic [31:0] data;
    bit          got;
    for (int i = 0; i < 5; i++) begin
      issue(rs[i], ws[i], as[i], ds[i], ops[i]);
      n_checks++;
      if (addrErr !== 1'b1 || busy !== 1'b0 || rdValid !== 1'b0 || rd !== exp_rd) begin
        n_errors++;
        $display("FAIL reject_%0d: got addrErr=%b busy=%b rdValid=%b rd=%h, want 1 0 0 %h",
                 i, addrErr, busy, rdValid, rd, exp_rd);
      end
      @(negedge clk);
      n_checks++;
      if (addrErr !== 1'b0 || busy !== 1'b0 || rdValid !== 1'b0) begin
        n_errors++;
        $display("FAIL reject_pulse_%0d: got addrErr=%b busy=%b rdValid=%b, want 0 0 0",
                 i, addrErr, busy, rdValid);
      end
      @(negedge clk);
      n_checks++;
      if (rdValid !== 1'b0 || rd !== exp_rd) begin
        n_errors++;
        $display("FAIL reject_late_%0d: got rdValid=%b rd=%h, want 0 %h", i, rdValid, rd, exp_rd);
      end
    end
    for (int i = 0; i < 4; i++) begin
      access(1'b1, 1'b0, la[i], 32'h0, 4'd0, data, got);
      n_checks++;
      if (!got || data !== le[i]) begin
        n_errors++;
        $display("FAIL post_reject_lw_%0d: addr=%h got valid=%0d rd=%h, want %h",
                 i, la[i], got, data, le[i]);
      end
    end
    exp_rd = 32'h0;
  endtask

  task automatic test_reset_mid_busy();
    logic [31:0] data;
    bit          got;
    issue(1'b0, 1'b1, 32'h40, 32'hCAFE_F00D, 4'd0);
    n_checks++;
    if (busy !== 1'b1) begin
      n_errors++;
      $display("FAIL abort_busy: got busy=%b, want 1", busy);
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rdValid !== 1'b0 || rd !== 32'h0) begin
      n_errors++;
      $display("FAIL abort_reset: got busy=%b rdValid=%b rd=%h, want 0 0 00000000", busy, rdValid, rd);
    end
    reset = 1'b0;
    got = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rdValid !== 1'b0) got = 1'b1;
    end
    n_checks++;
    if (got) begin
      n_errors++;
      $display("FAIL abort_no_valid: got rdValid pulse after aborted store, want none");
    end
    access(1'b1, 1'b0, 32'h40, 32'h0, 4'd0, data, got);
    n_checks++;
    if (!got || data !== 32'h0) begin
      n_errors++;
      $display("FAIL abort_lw_0x40: got valid=%0d rd=%h, want 00000000", got, data);
    end
    access(1'b1, 1'b0, 32'h10, 32'h0, 4'd0, data, got);
    n_checks++;
    if (!got || data !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_clears_0x10: got valid=%0d rd=%h, want 00000000", got, data);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] data;
    bit          got;
    access(1'b0, 1'b1, 32'h10, 32'h1234_5678, 4'd0, data, got);
    access(1'b0, 1'b1, 32'h20, 32'hA5A5_A5A5, 4'd0, data, got);
    @(negedge clk);
    memRead = 1'b1; memDst = 32'h10; memOp = 4'd0;
    @(negedge clk);
    memDst = 32'h20;
    n_checks++;
    if (busy !== 1'b1 || rdValid !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_e0: got busy=%b rdValid=%b, want 1 0", busy, rdValid);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || rdValid !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_e1: got busy=%b rdValid=%b, want 1 0", busy, rdValid);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rdValid !== 1'b1 || rd !== 32'h1234_5678) begin
      n_errors++;
      $display("FAIL hold_first: got busy=%b rdValid=%b rd=%h, want 0 1 12345678", busy, rdValid, rd);
    end
    @(negedge clk);
    memRead = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || rdValid !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_reaccept: got busy=%b rdValid=%b, want 1 0", busy, rdValid);
    end
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rdValid !== 1'b1 || rd !== 32'hA5A5_A5A5) begin
      n_errors++;
      $display("FAIL hold_second: got busy=%b rdValid=%b rd=%h, want 0 1 a5a5a5a5", busy, rdValid, rd);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || rdValid !== 1'b0) begin
      n_errors++;
      $display("FAIL hold_idle: got busy=%b rdValid=%b, want 0 0", busy, rdValid);
    end
    drive_idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    drive_idle();
    reset = 1'b1;
    test_reset();
    test_first_load();
    test_word_store_lanes();
    test_byte_half();
    test_reject();
    test_reset_mid_busy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/m_dm_lat.md
# m_dm_lat

Parametrised, multi-cycle successor to the MEM-stage data memory. It supports word, half and byte loads and stores with sign/zero extension and little-endian lane selection. Access latency is configurable and signalled to the pipeline stall logic through a busy/valid handshake. Misaligned, out-of-range and illegal-op requests are rejected with an error pulse and have no side effects.

## Interface
Parameters:
- DEPTH_WORDS, 4096: number of 32-bit words; byte span = DEPTH_WORDS*4.
- BASE_ADDR, 32'h0000_0000: byte address of word 0. Must be word-aligned.
- LATENCY, 2: cycles busy per accepted access. Legal range is ≥1.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- memRead  in  1  load request.
- memWrite  in  1  store request.
- memDst  in  32  byte address.
- memWd  in  32  store data; low byte/half used for sb/sh.
- memOp  in  4  access type: 0 word, 1 half unsigned, 2 half signed, 3 byte unsigned, 4 byte signed; 5–15 illegal.
- rd  out  32  load result; registered, held until the next load completes.
- busy  out  1  access in progress; registered.
- rdValid  out  1  one-cycle pulse on completion of any access (load or store).
- addrErr  out  1  one-cycle pulse on request rejection.

## Operation
- States:
  - IDLE.
  - BUSY, with down-counter cnt of width clog2(LATENCY).
- Accept condition: IDLE and (memRead | memWrite) at a rising edge.
  - On accept, latch memDst, memWd, memOp and direction into internal request registers.
  - Inputs are ignored while BUSY.
- Rejection: checked at the accepting edge. Any of the following sets addrErr=1 for the next cycle and leaves the state IDLE, with no memory or rd change:
  - memRead & memWrite.
  - Illegal memOp.
  - Word access with addr[1:0]≠0.
  - Half access with addr[0]≠0.
  - (addr−BASE_ADDR) ≥ DEPTH_WORDS*4, or addr < BASE_ADDR.
- Valid accept: state→BUSY, cnt←LATENCY−1.
- In BUSY:
  - If cnt≠0, decrement.
  - If cnt==0, at that edge commit the access, pulse rdValid, and go to IDLE.
- Store commit (little-endian, word index = (addr−BASE_ADDR)>>2):
  - Word: whole word written.
  - Half: memWd[15:0] written to bytes {addr[1],0} and {addr[1],1}.
  - Byte: memWd[7:0] written to byte addr[1:0].
  - Other lanes are preserved.
- Load commit:
  - Extract the lane(s), then zero-extend (ops 1, 3) or sign-extend (ops 2, 4) into rd.
  - Op 0 loads the full word.
- Store commit does not change rd.
- Reset:
  - All array words cleared to 0.
  - State IDLE, cnt=0.
  - rd=0, busy=0, rdValid=0, addrErr=0.
- Reset during BUSY aborts the access: a pending store is discarded and no rdValid is issued.
- A request still asserted in the cycle after completion (state IDLE) is accepted again. The requester must drop or replace its request in the rdValid cycle.

## Timing
- The accept edge is e0. busy=1 for cycles e0..e_LATENCY (LATENCY cycles).
- Commit happens at edge e_LATENCY. rdValid=1 and the rd update are visible in the cycle after e_LATENCY. busy=0 in that same cycle.
- LATENCY=1 gives one busy cycle, with rdValid in the second cycle after the request.
- Minimum issue interval is LATENCY+1 cycles.
- addrErr is visible in the cycle after e0; busy stays 0.
- Store followed by a load to the same address returns the new data; accesses are fully serialised.

## Test plan
All scenarios use LATENCY=2, BASE_ADDR=0, DEPTH_WORDS=4096.
- Reset, then lw 0x0 → busy high for 2 cycles; rdValid pulse with rd=0x00000000.
- sw 0x12345678 @0x10, then:
  - lbu 0x11 → rd=0x00000056.
  - lb 0x13 → rd=0x00000012.
  - lhu 0x12 → rd=0x00001234.
  - lw 0x10 → rd=0x12345678.
- sb 0x80 @0x20, then:
  - lb 0x20 → rd=0xFFFFFF80.
  - lbu 0x20 → rd=0x00000080.
  - sh 0xBEEF @0x22, then lw 0x20 → rd=0xBEEF0080.
- Rejections: lw 0x6, lh 0x5, lw 0x4000, memOp=7, read+write together.
  - Each → addrErr one-cycle pulse, busy=0, no rdValid, rd unchanged.
  - A subsequent lw of the touched words shows them unchanged.
- sw 0xCAFEF00D @0x40, then reset asserted in the first busy cycle → busy=0 after reset; lw 0x40 → rd=0x00000000.
- Hold memRead=1 @0x10 continuously → accepts at e0 and e3, with rdValid pulses in the cycles after e2 and e5. Inputs changed mid-BUSY (memDst=0x20) do not affect the first result.
